// File: rtl/cmd_word_encoder_if.sv
// Request/command bundle for cmd_word_encoder.
//   master : request source; drives req_valid/req_sel/req_data, observes the rest
//   slave  : the encoder; accepts requests, drives the COMMAND bus and status
//   req_valid/req_sel/req_data/req_ready : parameter-update handshake
//   command/cmd_active/sent              : serialised command word and status
//   reject                               : out-of-range setpoint dropped
//   level                                : FIFO occupancy
interface cmd_word_encoder_if #(
    parameter int unsigned DEPTH = 4
);
    localparam int unsigned LW = $clog2(DEPTH) + 1;

    logic          req_valid;
    logic [1:0]    req_sel;
    logic [13:0]   req_data;
    logic          req_ready;
    logic [15:0]   command;
    logic          cmd_active;
    logic          sent;
    logic          reject;
    logic [LW-1:0] level;

    modport master (
        output req_valid, req_sel, req_data,
        input  req_ready, command, cmd_active, sent, reject, level
    );

    modport slave (
        input  req_valid, req_sel, req_data,
        output req_ready, command, cmd_active, sent, reject, level
    );
endinterface

// File: rtl/cmd_word_encoder.sv
// Transmit-side command word encoder.
// Takes setpoint/P/I/D update requests over a valid/ready handshake, drops
// out-of-range setpoints, queues the rest in a FIFO and serialises them onto
// a 16-bit command bus {opcode[1:0], value[13:0]}. Each word is held for
// HOLD_CYCLES cycles and followed by GAP_CYCLES cycles of the idle word 0.
//   clk  : system clock, rising edge
//   rst  : asynchronous, active-high reset
//   bus  : cmd_word_encoder_if slave modport (handshake, command, status)
module cmd_word_encoder #(
    parameter int unsigned DEPTH       = 4,
    parameter int unsigned HOLD_CYCLES = 2,
    parameter int unsigned GAP_CYCLES  = 1,
    parameter logic [13:0] SP_MIN      = 14'h0DC0,
    parameter logic [13:0] SP_MAX      = 14'h3200
) (
    input  logic                clk,
    input  logic                rst,
    cmd_word_encoder_if.slave   bus
);
    localparam int unsigned AW   = $clog2(DEPTH);
    localparam int unsigned LW   = AW + 1;
    localparam int unsigned CMAX = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
    localparam int unsigned CW   = (CMAX > 1) ? $clog2(CMAX) : 1;

    typedef enum logic [1:0] {IDLE, DRIVE, GAP} state_t;

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [15:0]   command_q, command_n;
    logic          active_q, active_n;
    logic          sent_q, sent_n;
    logic          reject_q;

    logic [15:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [LW-1:0] count;

    logic          ready, xfer, sp_ok, accept, push, pop;

    assign ready  = (count != LW'(DEPTH));
    assign xfer   = bus.req_valid & ready;
    assign sp_ok  = (bus.req_data >= SP_MIN) && (bus.req_data <= SP_MAX);
    // Only setpoints are range-checked; gains pass unfiltered.
    assign accept = (bus.req_sel != 2'b00) | sp_ok;
    assign push   = xfer & accept;

    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        command_n = command_q;
        active_n  = active_q;
        sent_n    = 1'b0;
        pop       = 1'b0;
        unique case (state)
            IDLE: begin
                if (count != '0) begin
                    pop       = 1'b1;
                    command_n = mem[rd_ptr];
                    active_n  = 1'b1;
                    cnt_n     = CW'(HOLD_CYCLES - 1);
                    sent_n    = (HOLD_CYCLES == 1);
                    state_n   = DRIVE;
                end
            end
            DRIVE: begin
                if (cnt != '0) begin
                    cnt_n  = cnt - CW'(1);
                    // SENT is registered, so raise it on entry to the last hold cycle.
                    sent_n = (cnt == CW'(1));
                end else begin
                    command_n = '0;
                    active_n  = 1'b0;
                    cnt_n     = CW'(GAP_CYCLES - 1);
                    state_n   = GAP;
                end
            end
            GAP: begin
                if (cnt != '0) begin
                    cnt_n = cnt - CW'(1);
                end else if (count != '0) begin
                    pop       = 1'b1;
                    command_n = mem[rd_ptr];
                    active_n  = 1'b1;
                    cnt_n     = CW'(HOLD_CYCLES - 1);
                    sent_n    = (HOLD_CYCLES == 1);
                    state_n   = DRIVE;
                end else begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            command_q <= '0;
            active_q  <= 1'b0;
            sent_q    <= 1'b0;
            reject_q  <= 1'b0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            command_q <= command_n;
            active_q  <= active_n;
            sent_q    <= sent_n;
            reject_q  <= xfer & ~accept;
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + LW'(1);
                2'b01:   count <= count - LW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: entries are only read when count says they are valid.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= {bus.req_sel, bus.req_data};
    end

    assign bus.req_ready  = ready;
    assign bus.command    = command_q;
    assign bus.cmd_active = active_q;
    assign bus.sent       = sent_q;
    assign bus.reject     = reject_q;
    assign bus.level      = count;
endmodule

// File: tb/tb_cmd_word_encoder.sv
// Directed self-checking bench for cmd_word_encoder.
// Instance a: DEPTH=4, HOLD_CYCLES=2, GAP_CYCLES=1.
// Instance b: DEPTH=4, HOLD_CYCLES=1, GAP_CYCLES=3.
module tb_cmd_word_encoder;
    logic clk;
    logic rst;

    int unsigned n_checks;
    int unsigned n_fail;

    logic [15:0] em_a [$];
    logic [15:0] em_b [$];

    cmd_word_encoder_if #(.DEPTH(4)) bus_a ();
    cmd_word_encoder_if #(.DEPTH(4)) bus_b ();

    cmd_word_encoder #(
        .DEPTH(4), .HOLD_CYCLES(2), .GAP_CYCLES(1),
        .SP_MIN(14'h0DC0), .SP_MAX(14'h3200)
    ) dut (
        .clk(clk), .rst(rst), .bus(bus_a)
    );

    cmd_word_encoder #(
        .DEPTH(4), .HOLD_CYCLES(1), .GAP_CYCLES(3),
        .SP_MIN(14'h0DC0), .SP_MAX(14'h3200)
    ) dut_b (
        .clk(clk), .rst(rst), .bus(bus_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Record every word at its SENT pulse.
    always @(posedge clk) begin
        #1;
        if (!rst && bus_a.sent === 1'b1) em_a.push_back(bus_a.command);
        if (!rst && bus_b.sent === 1'b1) em_b.push_back(bus_b.command);
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    logic [15:0] exp1   [4]  = '{16'h1280, 16'h1280, 16'h0000, 16'h0000};
    logic        exp1_s [4]  = '{1'b0, 1'b1, 1'b0, 1'b0};
    logic [15:0] exp2   [8]  = '{16'h0000, 16'h8005, 16'h8005, 16'h0000,
                                 16'hC001, 16'hC001, 16'h0000, 16'h0000};
    logic        exp2_s [8]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    logic [15:0] exp4   [7]  = '{16'h1280, 16'h4100, 16'h4101, 16'h4102,
                                 16'h4103, 16'h4104, 16'h4105};
    logic [15:0] exp6   [8]  = '{16'h0000, 16'h0000, 16'h0000, 16'hC07F,
                                 16'h0000, 16'h0000, 16'h0000, 16'h0000};
    logic        exp6_s [8]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};

    initial begin
        logic was_ready;
        logic saw_full;
        logic timed_out;
        int unsigned stalls;
        int unsigned guard;

        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b0;
        bus_a.req_valid = 1'b0; bus_a.req_sel = 2'b00; bus_a.req_data = '0;
        bus_b.req_valid = 1'b0; bus_b.req_sel = 2'b00; bus_b.req_data = '0;

        // Reset state
        #1 rst = 1'b1;
        #1;
        chk("rst_command", 32'(bus_a.command), 32'h0);
        chk("rst_active",  32'(bus_a.cmd_active), 32'h0);
        chk("rst_sent",    32'(bus_a.sent), 32'h0);
        chk("rst_reject",  32'(bus_a.reject), 32'h0);
        chk("rst_level",   32'(bus_a.level), 32'h0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk("rst_ready", 32'(bus_a.req_ready), 32'h1);

        // Single setpoint: latency, hold, SENT, gap, return to idle
        bus_a.req_valid = 1'b1; bus_a.req_sel = 2'b00; bus_a.req_data = 14'h1280;
        tick();
        bus_a.req_valid = 1'b0;
        chk("t1_level_after_push", 32'(bus_a.level), 32'h1);
        chk("t1_cmd_before_pop",   32'(bus_a.command), 32'h0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("t1_command", 32'(bus_a.command), 32'(exp1[i]));
            chk("t1_sent",    32'(bus_a.sent), 32'(exp1_s[i]));
            chk("t1_reject",  32'(bus_a.reject), 32'h0);
        end
        chk("t1_emitted_count", 32'(em_a.size()), 32'd1);
        em_a.delete();

        // Back-to-back P, I, D
        bus_a.req_valid = 1'b1; bus_a.req_sel = 2'b01; bus_a.req_data = 14'h104C;
        tick();
        chk("t2_level_1", 32'(bus_a.level), 32'h1);
        bus_a.req_sel = 2'b10; bus_a.req_data = 14'h0005;
        tick();
        chk("t2_cmd_p0", 32'(bus_a.command), 32'h504C);
        chk("t2_sent_p0", 32'(bus_a.sent), 32'h0);
        bus_a.req_sel = 2'b11; bus_a.req_data = 14'h0001;
        tick();
        bus_a.req_valid = 1'b0;
        chk("t2_cmd_p1", 32'(bus_a.command), 32'h504C);
        chk("t2_sent_p1", 32'(bus_a.sent), 32'h1);
        chk("t2_level_2", 32'(bus_a.level), 32'h2);
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("t2_command", 32'(bus_a.command), 32'(exp2[i]));
            chk("t2_active",  32'(bus_a.cmd_active), 32'(exp2[i] != 16'h0));
            chk("t2_sent",    32'(bus_a.sent), 32'(exp2_s[i]));
        end
        chk("t2_emitted_count", 32'(em_a.size()), 32'd3);
        em_a.delete();

        // Setpoint bounds
        bus_a.req_valid = 1'b1; bus_a.req_sel = 2'b00; bus_a.req_data = 14'h0DC0;
        tick();
        bus_a.req_data = 14'h3200;
        tick();
        chk("t3_reject_in_range", 32'(bus_a.reject), 32'h0);
        bus_a.req_data = 14'h0DBF;
        tick();
        chk("t3_reject_low",  32'(bus_a.reject), 32'h1);
        chk("t3_level_low",   32'(bus_a.level), 32'h1);
        bus_a.req_data = 14'h3201;
        tick();
        chk("t3_reject_high", 32'(bus_a.reject), 32'h1);
        chk("t3_level_high",  32'(bus_a.level), 32'h1);
        bus_a.req_valid = 1'b0;
        tick();
        chk("t3_reject_clear", 32'(bus_a.reject), 32'h0);
        repeat (8) tick();
        chk("t3_emitted_count", 32'(em_a.size()), 32'd2);
        if (em_a.size() == 2) begin
            chk("t3_word0", 32'(em_a[0]), 32'h0DC0);
            chk("t3_word1", 32'(em_a[1]), 32'h3200);
        end
        em_a.delete();

        // Backpressure: one word in flight, then 6 P requests with valid held high
        bus_a.req_valid = 1'b1; bus_a.req_sel = 2'b00; bus_a.req_data = 14'h1280;
        tick();
        bus_a.req_sel = 2'b01;
        saw_full  = 1'b0;
        timed_out = 1'b0;
        stalls    = 0;
        for (int i = 0; i < 6; i++) begin
            bus_a.req_data = 14'h0100 + 14'(i);
            guard = 0;
            do begin
                was_ready = bus_a.req_ready;
                if (!was_ready) stalls++;
                if (bus_a.level == 3'd4 && !bus_a.req_ready) saw_full = 1'b1;
                tick();
                guard++;
            end while (!was_ready && guard < 20);
            if (!was_ready) timed_out = 1'b1;
        end
        bus_a.req_valid = 1'b0;
        chk("t4_timeout",   32'(timed_out), 32'h0);
        chk("t4_saw_full",  32'(saw_full), 32'h1);
        chk("t4_stalled",   32'(stalls != 0), 32'h1);
        repeat (30) tick();
        chk("t4_emitted_count", 32'(em_a.size()), 32'd7);
        if (em_a.size() == 7) begin
            for (int i = 0; i < 7; i++) chk("t4_word", 32'(em_a[i]), 32'(exp4[i]));
        end
        chk("t4_level_drained", 32'(bus_a.level), 32'h0);
        em_a.delete();

        // Reset during the first DRIVE cycle with 3 entries queued
        bus_a.req_valid = 1'b1; bus_a.req_sel = 2'b10; bus_a.req_data = 14'h0011;
        tick();
        bus_a.req_data = 14'h0022;
        tick();
        bus_a.req_data = 14'h0033;
        tick();
        bus_a.req_data = 14'h0044;
        tick();
        bus_a.req_data = 14'h0055;
        tick();
        bus_a.req_valid = 1'b0;
        chk("t5_pre_cmd",   32'(bus_a.command), 32'h8022);
        chk("t5_pre_level", 32'(bus_a.level), 32'h3);
        rst = 1'b1;
        #1;
        chk("t5_rst_cmd",    32'(bus_a.command), 32'h0);
        chk("t5_rst_level",  32'(bus_a.level), 32'h0);
        chk("t5_rst_active", 32'(bus_a.cmd_active), 32'h0);
        tick();
        rst = 1'b0;
        em_a.delete();
        chk("t5_ready", 32'(bus_a.req_ready), 32'h1);
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("t5_quiet_cmd", 32'(bus_a.command), 32'h0);
        end
        chk("t5_emitted_count", 32'(em_a.size()), 32'd0);

        // HOLD_CYCLES=1, GAP_CYCLES=3 instance
        bus_b.req_valid = 1'b1; bus_b.req_sel = 2'b01; bus_b.req_data = 14'h0123;
        tick();
        bus_b.req_sel = 2'b11; bus_b.req_data = 14'h007F;
        tick();
        bus_b.req_valid = 1'b0;
        chk("t6_cmd_x",  32'(bus_b.command), 32'h4123);
        chk("t6_sent_x", 32'(bus_b.sent), 32'h1);
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("t6_command", 32'(bus_b.command), 32'(exp6[i]));
            chk("t6_sent",    32'(bus_b.sent), 32'(exp6_s[i]));
        end
        chk("t6_emitted_count", 32'(em_b.size()), 32'd2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
